// File: rtl/traffic_light_sequencer.sv
// rtl/traffic_light_sequencer.sv - timed NS/EW/WALK phase sequencer driven by the 2-bit traffic mode
// Every exit from a green passes through a full yellow and a full all-red before anything else runs.
module traffic_light_sequencer #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 5,
  parameter int BLINK_TICKS  = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic [2:0] nsLamp,
  output logic [2:0] ewLamp,
  output logic       walk,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    AR1   = 4'd0,
    NS_G  = 4'd1,
    NS_Y  = 4'd2,
    AR2   = 4'd3,
    EW_G  = 4'd4,
    EW_Y  = 4'd5,
    PED   = 4'd6,
    NIGHT = 4'd7,
    EMG   = 4'd8
  } state_t;

  localparam logic [1:0] MODE_DAY   = 2'b00;
  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMG   = 2'b11;

  localparam logic [CNT_W-1:0] LD_G  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_W  = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] LD_B  = CNT_W'(BLINK_TICKS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             ped_pend, ped_nxt, ped_req;
  logic             blink, blink_nxt;
  logic             expired;

  function automatic logic [CNT_W-1:0] load_of(input state_t s);
    case (s)
      NS_G, EW_G: load_of = LD_G;
      NS_Y, EW_Y: load_of = LD_Y;
      PED:        load_of = LD_W;
      NIGHT:      load_of = LD_B;
      default:    load_of = LD_AR;
    endcase
  endfunction

  // {nsLamp, ewLamp, walk}; lamp bits are {red, yellow, green}
  function automatic logic [6:0] lamps_of(input state_t s, input logic b);
    case (s)
      NS_G:    lamps_of = {3'b001, 3'b100, 1'b0};
      NS_Y:    lamps_of = {3'b010, 3'b100, 1'b0};
      EW_G:    lamps_of = {3'b100, 3'b001, 1'b0};
      EW_Y:    lamps_of = {3'b100, 3'b010, 1'b0};
      PED:     lamps_of = {3'b100, 3'b100, 1'b1};
      NIGHT:   lamps_of = {1'b0, b, 1'b0, b, 2'b00, 1'b0};
      default: lamps_of = {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    timer_nxt = timer - CNT_W'(1);
    blink_nxt = blink;
    ped_req   = ped_pend | (mode == MODE_PED);
    ped_nxt   = ped_req;
    expired   = (timer == '0);

    case (state)
      AR1, AR2: begin
        if (expired) begin
          if (mode == MODE_EMG)        state_nxt = EMG;
          else if (ped_req)            state_nxt = PED;
          else if (mode == MODE_NIGHT) state_nxt = NIGHT;
          else                         state_nxt = (state == AR1) ? NS_G : EW_G;
        end
      end
      NS_G:  if (expired || mode == MODE_EMG) state_nxt = NS_Y;
      EW_G:  if (expired || mode == MODE_EMG) state_nxt = EW_Y;
      NS_Y:  if (expired) state_nxt = AR2;
      EW_Y:  if (expired) state_nxt = AR1;
      PED:   if (expired) state_nxt = AR1;
      NIGHT: begin
        if (mode == MODE_EMG)                  state_nxt = EMG;
        else if (mode == MODE_DAY || ped_req)  state_nxt = AR1;
        else if (expired) begin
          blink_nxt = ~blink;
          timer_nxt = LD_B;
        end
      end
      EMG:     if (mode != MODE_EMG) state_nxt = AR1;
      default: state_nxt = AR1;
    endcase

    // Every entry restarts the phase timer; night always starts with the lamps lit.
    if (state_nxt != state) begin
      timer_nxt = load_of(state_nxt);
      blink_nxt = (state_nxt == NIGHT);
      if (state_nxt == PED) ped_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AR1;
      timer    <= LD_AR;
      ped_pend <= 1'b0;
      blink    <= 1'b0;
      nsLamp   <= 3'b100;
      ewLamp   <= 3'b100;
      walk     <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      ped_pend <= ped_nxt;
      blink    <= blink_nxt;
      {nsLamp, ewLamp, walk} <= lamps_of(state_nxt, blink_nxt);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// tb/tb_traffic_light_sequencer.sv - directed and randomized checks against a phase-duration reference model
module tb_traffic_light_sequencer;

  localparam int G = 8, Y = 3, AR = 2, W = 5, B = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic [2:0] nsLamp, ewLamp;
  logic       walk;
  logic [3:0] phase;

  int errors = 0;
  int checks = 0;

  traffic_light_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .nsLamp(nsLamp), .ewLamp(ewLamp), .walk(walk), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_AR1, M_NSG, M_NSY, M_AR2, M_EWG, M_EWY, M_PED, M_NIGHT, M_EMG} mstate_t;

  mstate_t m_state;
  int      m_rem;
  bit      m_pend;
  bit      m_blink;

  function automatic int dur(input mstate_t s);
    case (s)
      M_NSG, M_EWG: return G;
      M_NSY, M_EWY: return Y;
      M_PED:        return W;
      M_NIGHT:      return B;
      default:      return AR;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_AR1;
    m_rem   = AR;
    m_pend  = 0;
    m_blink = 0;
  endtask

  // One clock edge: m_rem is the number of cycles left in the current phase, including this one.
  task automatic model_step(input logic [1:0] m);
    mstate_t nxt;
    bit      last;
    bit      pend_in;
    nxt     = m_state;
    last    = (m_rem == 1);
    pend_in = m_pend || (m == 2'b10);
    case (m_state)
      M_AR1, M_AR2:
        if (last) begin
          if (m == 2'b11)      nxt = M_EMG;
          else if (pend_in)    nxt = M_PED;
          else if (m == 2'b01) nxt = M_NIGHT;
          else                 nxt = (m_state == M_AR1) ? M_NSG : M_EWG;
        end
      M_NSG: if (last || m == 2'b11) nxt = M_NSY;
      M_EWG: if (last || m == 2'b11) nxt = M_EWY;
      M_NSY: if (last) nxt = M_AR2;
      M_EWY: if (last) nxt = M_AR1;
      M_PED: if (last) nxt = M_AR1;
      M_NIGHT:
        if (m == 2'b11)                  nxt = M_EMG;
        else if (m == 2'b00 || pend_in)  nxt = M_AR1;
      M_EMG: if (m != 2'b11) nxt = M_AR1;
      default: nxt = M_AR1;
    endcase
    m_pend = pend_in;
    if (nxt != m_state) begin
      m_state = nxt;
      m_rem   = dur(nxt);
      m_blink = (nxt == M_NIGHT);
      if (nxt == M_PED) m_pend = 0;
    end else if (m_state == M_NIGHT && last) begin
      m_blink = !m_blink;
      m_rem   = B;
    end else if (m_rem > 1) begin
      m_rem = m_rem - 1;
    end
  endtask

  function automatic logic [6:0] expected_out();
    case (m_state)
      M_NSG:   return {3'b001, 3'b100, 1'b0};
      M_NSY:   return {3'b010, 3'b100, 1'b0};
      M_EWG:   return {3'b100, 3'b001, 1'b0};
      M_EWY:   return {3'b100, 3'b010, 1'b0};
      M_PED:   return {3'b100, 3'b100, 1'b1};
      M_NIGHT: return {1'b0, m_blink, 1'b0, m_blink, 2'b00, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [6:0] e;
    e = expected_out();
    check({tag, ".ns"},   nsLamp,       e[6:4]);
    check({tag, ".ew"},   ewLamp,       e[3:1]);
    check({tag, ".walk"}, {2'b00, walk}, {2'b00, e[0]});
  endtask

  task automatic step(input logic [1:0] m, input string tag);
    mode = m;
    @(posedge clk);
    model_step(m);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic steps(input logic [1:0] m, input int n, input string tag);
    for (int i = 0; i < n; i++) step(m, tag);
  endtask

  task automatic run_until(input mstate_t target, input string tag);
    int budget;
    budget = 100;
    while (m_state != target && budget > 0) begin
      step(2'b00, tag);
      budget--;
    end
    checks++;
    assert (m_state == target) else begin
      errors++;
      $error("FAIL %s_reach observed=%0d expected=%0d", tag, m_state, target);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mode  = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset.ns", nsLamp, 3'b100);
    check("reset.ew", ewLamp, 3'b100);
    check("reset.walk", {2'b00, walk}, 3'b000);
    rst_n = 1'b1;

    steps(2'b00, 30, "day");

    run_until(M_NSG, "emg");
    steps(2'b00, 2, "emg");
    steps(2'b11, 10, "emg");
    steps(2'b00, 12, "emg");

    run_until(M_EWG, "ped");
    step(2'b10, "ped");
    steps(2'b00, 30, "ped");

    run_until(M_NSG, "night");
    steps(2'b01, 30, "night");
    steps(2'b00, 12, "night");

    run_until(M_NSY, "both");
    step(2'b10, "both");
    steps(2'b11, 8, "both");
    steps(2'b00, 20, "both");

    run_until(M_NSY, "arst");
    step(2'b00, "arst");
    #2 rst_n = 1'b0;
    #1;
    check("arst.ns", nsLamp, 3'b100);
    check("arst.ew", ewLamp, 3'b100);
    check("arst.walk", {2'b00, walk}, 3'b000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    steps(2'b00, 30, "arst");

    for (int seg = 0; seg < 150; seg++) begin
      int r;
      int hold;
      logic [1:0] m;
      r    = $urandom_range(0, 9);
      hold = $urandom_range(1, 20);
      if (r < 5)       m = 2'b00;
      else if (r < 7)  m = 2'b01;
      else if (r == 7) begin m = 2'b10; hold = $urandom_range(1, 2); end
      else             m = 2'b11;
      steps(m, hold, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
